// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: word geometry, the
// buffered fetch entry, and word alignment of redirect targets.
package fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [0:WORD_W-1] DEFAULT_RESET_PC = 32'd0;

    typedef logic [0:WORD_W-1] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    // Bits [30:31] are the byte offset in big-endian numbering.
    function automatic word_t align_word(input word_t addr);
        return {addr[0:WORD_W-3], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH entries of
// {instruction, pc}, flushable in one cycle, head visible combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [0:2*WORD_W-1] din,
    output logic                full,
    output logic                empty,
    output logic [0:2*WORD_W-1] head
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [0:2*WORD_W-1]  mem [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the head is forced to zero while empty, so stale words never reach decode.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the fetch PC, issues credit-limited word reads to
// instruction memory and queues the returned words for decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [0:WORD_W-1] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_gnt,
    input  logic [0:31] imem_rdata,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    output logic [0:31] instr,
    output logic [0:31] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    word_t         pc;
    word_t         req_pc;
    logic          inflight;
    logic          discard;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          push;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Credits count buffered plus in-flight words, so a granted read always has a slot.
    assign imem_req   = rst && (cnt < CREDITS) && !redirect;
    assign imem_addr  = pc;
    assign grant      = imem_req && imem_gnt;
    assign push       = inflight && !discard && !fifo_full;
    assign drop       = inflight && discard;
    assign pop        = instr_valid && instr_ready && !redirect;
    assign push_entry = '{instr: imem_rdata, pc: req_pc};

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            cnt      <= '0;
        end else begin
            discard <= redirect;
            if (redirect) begin
                // The response landing on this edge is dropped together with the buffer.
                pc       <= align_word(redirect_pc);
                inflight <= 1'b0;
                cnt      <= '0;
            end else begin
                inflight <= grant;
                if (grant) begin
                    req_pc <= pc;
                    pc     <= pc + word_t'(INSTR_BYTES);
                end
                cnt <= cnt + CW'(grant) - CW'(pop) - CW'(drop);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_entry)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: hand-derived vector table, directed redirect,
// wrap and reset sequences, then random traffic against a queue model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h100;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] DATA_KEY = 32'hDEAD0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_gnt;
    logic [0:31] imem_rdata;
    logic        redirect;
    logic [0:31] redirect_pc;
    logic [0:31] instr;
    logic [0:31] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    // Reference model: fetch pc, queue of buffered addresses, one in-flight slot.
    logic [31:0] m_pc;
    logic [31:0] m_buf[$];
    bit          m_infl;
    logic [31:0] m_infl_addr;

    // Outputs sampled mid-cycle by the most recent step.
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    typedef struct {
        bit          gnt;
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_buf.delete();
        m_infl = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare at negedge+1, memory/model after posedge.
    task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rp);
        bit          mreq;
        bit          gs;
        logic [31:0] ga;
        @(negedge clk);
        imem_gnt    = g;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rp;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = instr_pc;
        s_instr = instr;
        mreq = ((m_buf.size() + int'(m_infl)) < DEPTH) && !rd;
        check("req", s_req, mreq);
        check("addr", s_addr, m_pc);
        check("valid", s_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            check("instr_pc", s_pc, m_buf[0]);
            check("instr", s_instr, m_buf[0] ^ DATA_KEY);
        end
        gs = imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = gs ? (ga ^ DATA_KEY) : $urandom();
        if (rd) begin
            m_buf.delete();
            m_infl = 1'b0;
            m_pc   = rp & ~32'h3;
        end else begin
            if (m_buf.size() != 0 && r) void'(m_buf.pop_front());
            if (m_infl) m_buf.push_back(m_infl_addr);
            m_infl = mreq && g;
            if (m_infl) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    // Assert reset between edges, check it takes effect at once, release a cycle later.
    task automatic do_reset();
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen_108;
        logic [31:0] rp;
        logic [31:0] wrap_addr[3];
        logic [31:0] wrap_pc[3];

        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        model_reset();
        do_reset();

        // Stream from RESET_PC with decode stalled, then drained, then memory stalled.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h100};
        for (int i = 4; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h100};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h104};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h108};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h10C};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h11C, 1'b1, 32'h110};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h11C, 1'b1, 32'h110};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h11C, 1'b1, 32'h110};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0);
            check("tbl_req", s_req, tbl[i].exp_req);
            check("tbl_addr", s_addr, tbl[i].exp_addr);
            check("tbl_valid", s_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check("tbl_pc", s_pc, tbl[i].exp_pc);
        end

        // Leaves three entries buffered, then reset lands mid-stream.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();

        // Redirect the cycle after the grant to 0x108.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h2000);
        check("redir_no_req", s_req, 1'b0);
        seen_108 = s_valid && (s_pc == 32'h108);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_valid && s_pc == 32'h108) seen_108 = 1'b1;
            if (k == 0) begin
                check("redir_addr", s_addr, 32'h2000);
                check("redir_flushed", s_valid, 1'b0);
            end
            if (k == 2) begin
                check("redir_first_valid", s_valid, 1'b1);
                check("redir_first_pc", s_pc, 32'h2000);
            end
        end
        check("redir_no_108", seen_108, 1'b0);

        // Misaligned redirect near the top of the address space, then wrap.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (k < 3) wrap_addr[k] = s_addr;
            if (k >= 2) wrap_pc[k-2] = s_valid ? s_pc : 32'hBAD0_BAD0;
        end
        check("wrap_addr0", wrap_addr[0], 32'hFFFF_FFF8);
        check("wrap_addr1", wrap_addr[1], 32'hFFFF_FFFC);
        check("wrap_addr2", wrap_addr[2], 32'h0000_0000);
        check("wrap_pc0", wrap_pc[0], 32'hFFFF_FFF8);
        check("wrap_pc1", wrap_pc[1], 32'hFFFF_FFFC);
        check("wrap_pc2", wrap_pc[2], 32'h0000_0000);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rp = $urandom();
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
